// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for a stable lock,
// then releases the downstream reset; retries on timeout and faults out.
// Ports: refclk/rst (async, active-low), pll_locked (async), force_relock,
//   clear_fault in; pll_rst, sys_rst_n, ready, fault, lock_lost,
//   retry_cnt[3:0], lost_cnt[7:0], state[2:0] out (all registered).
module pll_lock_sequencer #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 64,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int MAX_RETRIES  = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       force_relock,
   input  logic       clear_fault,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fault,
   output logic       lock_lost,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam int C1   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
   localparam int CMAX = (C1 > LOCK_TIMEOUT) ? C1 : LOCK_TIMEOUT;
   localparam int CW   = $clog2(CMAX);

   localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]    RTY_MAX  = 4'(MAX_RETRIES);

   state_t          st, st_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [3:0]      retry_nx;
   logic            lost_ev;
   logic            sync1, locked_s;

   // One shared timer: each state clears it on entry, so it only ever
   // measures time spent in the current state.
   always_comb begin
      st_nx    = st;
      cnt_nx   = cnt;
      retry_nx = retry_cnt;
      lost_ev  = 1'b0;
      unique case (st)
         RESET_PLL: begin
            if (cnt == RST_LAST) begin
               st_nx  = WAIT_LOCK;
               cnt_nx = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               st_nx  = STABILIZE;
               cnt_nx = '0;
            end else if (cnt == TO_LAST) begin
               cnt_nx = '0;
               if (retry_cnt == RTY_MAX) begin
                  st_nx = FAULT;
               end else begin
                  st_nx    = RESET_PLL;
                  retry_nx = retry_cnt + 4'd1;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               st_nx  = WAIT_LOCK;
               cnt_nx = '0;
            end else if (cnt == STB_LAST) begin
               st_nx    = RUN;
               cnt_nx   = '0;
               retry_nx = 4'd0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         RUN: begin
            // Lock loss wins over a coincident relock request.
            if (!locked_s) begin
               st_nx   = RESET_PLL;
               cnt_nx  = '0;
               lost_ev = 1'b1;
            end else if (force_relock) begin
               st_nx  = RESET_PLL;
               cnt_nx = '0;
            end
         end
         FAULT: begin
            if (clear_fault) begin
               st_nx    = RESET_PLL;
               cnt_nx   = '0;
               retry_nx = 4'd0;
            end
         end
         default: begin
            st_nx  = RESET_PLL;
            cnt_nx = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so that they are registered
   // yet line up with the state they describe.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         sync1     <= 1'b0;
         locked_s  <= 1'b0;
         st        <= RESET_PLL;
         cnt       <= '0;
         retry_cnt <= 4'd0;
         lost_cnt  <= 8'd0;
         lock_lost <= 1'b0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         sync1     <= pll_locked;
         locked_s  <= sync1;
         st        <= st_nx;
         cnt       <= cnt_nx;
         retry_cnt <= retry_nx;
         lock_lost <= lost_ev;
         if (lost_ev && (lost_cnt != 8'hFF)) begin
            lost_cnt <= lost_cnt + 8'd1;
         end
         pll_rst   <= (st_nx == RESET_PLL) || (st_nx == FAULT);
         sys_rst_n <= (st_nx == RUN);
         ready     <= (st_nx == RUN);
         fault     <= (st_nx == FAULT);
      end
   end

   assign state = st;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with
// RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
module tb_pll_lock_sequencer;

   logic       refclk = 1'b0;
   logic       rst = 1'b0;
   logic       pll_locked = 1'b0;
   logic       force_relock = 1'b0;
   logic       clear_fault = 1'b0;
   logic       pll_rst, sys_rst_n, ready, fault, lock_lost;
   logic [3:0] retry_cnt;
   logic [7:0] lost_cnt;
   logic [2:0] state;

   int n_chk = 0;
   int n_fail = 0;

   always #5 refclk = ~refclk;

   pll_lock_sequencer #(
      .RST_CYCLES(4),
      .LOCK_STABLE(8),
      .LOCK_TIMEOUT(32),
      .MAX_RETRIES(2)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .pll_locked(pll_locked),
      .force_relock(force_relock),
      .clear_fault(clear_fault),
      .pll_rst(pll_rst),
      .sys_rst_n(sys_rst_n),
      .ready(ready),
      .fault(fault),
      .lock_lost(lock_lost),
      .retry_cnt(retry_cnt),
      .lost_cnt(lost_cnt),
      .state(state)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_run(input string tag);
      int k;
      k = 0;
      while (state != 3'd3 && k < 64) begin
         tick(1);
         k++;
      end
      chk(tag, int'(state), 3);
   endtask

   initial begin
      // reset asserted, no clock edge needed for values
      #12;
      chk("rst_state", int'(state), 0);
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_sys_rst_n", int'(sys_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_lost", int'(lost_cnt), 0);
      chk("rst_retry", int'(retry_cnt), 0);
      @(negedge refclk);
      rst = 1'b1;

      // nominal: 4 cycles of PLL reset, lock rises 10 cycles after release
      tick(1);
      chk("e1_state", int'(state), 0);
      chk("e1_pll_rst", int'(pll_rst), 1);
      chk("e1_lock_lost", int'(lock_lost), 0);
      tick(2);
      chk("e3_pll_rst", int'(pll_rst), 1);
      tick(1);
      chk("e4_state", int'(state), 1);
      chk("e4_pll_rst", int'(pll_rst), 0);
      chk("e4_sys_rst_n", int'(sys_rst_n), 0);
      tick(6);
      pll_locked = 1'b1;
      tick(3);
      chk("nom_stab_enter", int'(state), 2);
      tick(7);
      chk("nom_stab_last", int'(state), 2);
      chk("nom_stab_sysrst", int'(sys_rst_n), 0);
      tick(1);
      chk("nom_run", int'(state), 3);
      chk("nom_sys_rst_n", int'(sys_rst_n), 1);
      chk("nom_ready", int'(ready), 1);
      chk("nom_pll_rst", int'(pll_rst), 0);
      chk("nom_retry", int'(retry_cnt), 0);

      // forced relock: no lock_lost, lost_cnt unchanged
      force_relock = 1'b1;
      tick(1);
      force_relock = 1'b0;
      chk("frc_state", int'(state), 0);
      chk("frc_lock_lost", int'(lock_lost), 0);
      chk("frc_lost", int'(lost_cnt), 0);
      chk("frc_sys_rst_n", int'(sys_rst_n), 0);
      chk("frc_ready", int'(ready), 0);

      // glitch seen at stable count 5
      tick(8);
      chk("gl_stab", int'(state), 2);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(1);
      chk("gl_cnt5", int'(state), 2);
      tick(1);
      chk("gl_back_wait", int'(state), 1);
      chk("gl_sys_rst_n", int'(sys_rst_n), 0);
      tick(1);
      chk("gl_restab", int'(state), 2);
      tick(7);
      chk("gl_full_count", int'(state), 2);
      tick(1);
      chk("gl_run", int'(state), 3);

      // loss of lock in RUN
      pll_locked = 1'b0;
      tick(2);
      chk("loss_sync_run", int'(state), 3);
      chk("loss_sync_ready", int'(ready), 1);
      tick(1);
      chk("loss_state", int'(state), 0);
      chk("loss_pulse", int'(lock_lost), 1);
      chk("loss_cnt", int'(lost_cnt), 1);
      chk("loss_sys_rst_n", int'(sys_rst_n), 0);
      chk("loss_ready", int'(ready), 0);
      tick(1);
      chk("loss_pulse_end", int'(lock_lost), 0);
      pll_locked = 1'b1;
      tick(12);
      chk("relock_run", int'(state), 3);

      // lock drop and force_relock together
      pll_locked = 1'b0;
      tick(2);
      force_relock = 1'b1;
      tick(1);
      force_relock = 1'b0;
      chk("sim_state", int'(state), 0);
      chk("sim_pulse", int'(lock_lost), 1);
      chk("sim_cnt", int'(lost_cnt), 2);
      tick(1);
      chk("sim_single", int'(state), 0);
      chk("sim_pulse_end", int'(lock_lost), 0);
      chk("sim_cnt_hold", int'(lost_cnt), 2);
      pll_locked = 1'b1;
      wait_run("sim_relock");

      // repeated losses saturate lost_cnt
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         tick(3);
         chk("rep_pulse", int'(lock_lost), 1);
         pll_locked = 1'b1;
         wait_run("rep_relock");
      end
      chk("rep_sat", int'(lost_cnt), 255);

      // asynchronous reset mid-RUN
      #3;
      rst = 1'b0;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_pll_rst", int'(pll_rst), 1);
      chk("arst_sys_rst_n", int'(sys_rst_n), 0);
      chk("arst_ready", int'(ready), 0);
      chk("arst_lost", int'(lost_cnt), 0);
      chk("arst_lock_lost", int'(lock_lost), 0);
      pll_locked = 1'b0;
      #2;
      rst = 1'b1;

      // timeout retries then FAULT
      tick(4);
      chk("to_wait1", int'(state), 1);
      force_relock = 1'b1;
      clear_fault = 1'b1;
      tick(1);
      force_relock = 1'b0;
      clear_fault = 1'b0;
      chk("to_ignore", int'(state), 1);
      chk("to_ignore_rty", int'(retry_cnt), 0);
      tick(30);
      chk("to_last_wait", int'(state), 1);
      chk("to_rty0", int'(retry_cnt), 0);
      tick(1);
      chk("to_rst1", int'(state), 0);
      chk("to_rty1", int'(retry_cnt), 1);
      chk("to_pll_rst1", int'(pll_rst), 1);
      tick(36);
      chk("to_rst2", int'(state), 0);
      chk("to_rty2", int'(retry_cnt), 2);
      tick(35);
      chk("to_wait3", int'(state), 1);
      tick(1);
      chk("flt_state", int'(state), 4);
      chk("flt_fault", int'(fault), 1);
      chk("flt_pll_rst", int'(pll_rst), 1);
      chk("flt_sys_rst_n", int'(sys_rst_n), 0);
      chk("flt_ready", int'(ready), 0);
      chk("flt_rty", int'(retry_cnt), 2);
      tick(5);
      chk("flt_hold", int'(state), 4);
      chk("flt_hold_fault", int'(fault), 1);
      clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      chk("clr_state", int'(state), 0);
      chk("clr_rty", int'(retry_cnt), 0);
      chk("clr_fault", int'(fault), 0);
      chk("clr_pll_rst", int'(pll_rst), 1);
      tick(4);
      chk("clr_wait", int'(state), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16: PLL reset hold length in refclk cycles, minimum 2.
REQ-002 The block SHALL have parameter LOCK_STABLE, default 64: consecutive synced-lock cycles required before release, minimum 2.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 4096: WAIT_LOCK cycles allowed per attempt.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3: timeout retries allowed before FAULT, range 0..15.
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port pll_locked, input, 1 bit: PLL lock flag, asynchronous to refclk.
REQ-008 The block SHALL have port force_relock, input, 1 bit: single-cycle request to re-sequence the PLL.
REQ-009 The block SHALL have port clear_fault, input, 1 bit: single-cycle request to leave FAULT.
REQ-010 The block SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL.
REQ-011 The block SHALL have port sys_rst_n, output, 1 bit: active-low reset to logic clocked by the PLL output.
REQ-012 The block SHALL have port ready, output, 1 bit: high only in RUN.
REQ-013 The block SHALL have port fault, output, 1 bit: high only in FAULT.
REQ-014 The block SHALL have port lock_lost, output, 1 bit: one-cycle pulse on loss of lock in RUN.
REQ-015 The block SHALL have port retry_cnt, output, 4 bits: timeout retries used in the current sequence.
REQ-016 The block SHALL have port lost_cnt, output, 8 bits: saturating count of RUN lock losses.
REQ-017 The block SHALL have port state, output, 3 bits: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.

Function
REQ-018 pll_locked SHALL pass through a two-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-019 RESET_PLL: pll_rst=1, sys_rst_n=0; after exactly RST_CYCLES cycles in this state, go to WAIT_LOCK with the timer cleared.
REQ-020 WAIT_LOCK: pll_rst=0, sys_rst_n=0; if locked_s=1, go to STABILIZE with the stable counter cleared.
REQ-021 WAIT_LOCK timeout: if LOCK_TIMEOUT cycles pass without locked_s, go to FAULT when retry_cnt==MAX_RETRIES; otherwise increment retry_cnt and go to RESET_PLL.
REQ-022 STABILIZE: if locked_s=0 on any cycle, return to WAIT_LOCK with the timer cleared; after LOCK_STABLE consecutive high cycles, go to RUN.
REQ-023 RUN entry: sys_rst_n=1 and ready=1 from the first RUN cycle; retry_cnt cleared to 0.
REQ-024 RUN: locked_s=0 SHALL, on the same edge, drive sys_rst_n=0 and ready=0, pulse lock_lost for 1 cycle, increment lost_cnt (saturate at 255), and go to RESET_PLL.
REQ-025 RUN: force_relock=1 SHALL go to RESET_PLL without lock_lost and without changing lost_cnt.
REQ-026 force_relock=1 and locked_s=0 in the same RUN cycle SHALL cause a single transition with lock_lost behaviour (REQ-024).
REQ-027 force_relock outside RUN SHALL be ignored.
REQ-028 FAULT: pll_rst=1, sys_rst_n=0, fault=1; clear_fault=1 SHALL clear retry_cnt and go to RESET_PLL; otherwise remain in FAULT.
REQ-029 clear_fault outside FAULT SHALL be ignored.
REQ-030 All outputs SHALL be registered; sys_rst_n SHALL never be high outside RUN.

Reset
REQ-031 While rst=0, and on the first edge after release: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, fault=0, lock_lost=0, retry_cnt=0, lost_cnt=0, synchronizer and counters at 0.
REQ-032 Asserting rst in any state, including mid-RUN, SHALL force the REQ-031 values immediately (asynchronous).

Verification
(Parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.)
REQ-033 Nominal: pll_locked rises 10 cycles after release -> pll_rst high for 4 cycles; RUN reached 2 sync + 8 stable cycles after the rise; sys_rst_n=1, ready=1.
REQ-034 Glitch: locked drops for 1 cycle at stable count 5 -> return to WAIT_LOCK; full 8-cycle count restarts; sys_rst_n stays 0.
REQ-035 Timeout: pll_locked held 0 -> retry_cnt reaches 1, then 2, then FAULT (fault=1, pll_rst=1); clear_fault -> RESET_PLL with retry_cnt=0.
REQ-036 Loss in RUN: drop locked -> sys_rst_n=0, one-cycle lock_lost, lost_cnt=1, RESET_PLL; re-lock returns to RUN. Repeat 300 times -> lost_cnt=255.
REQ-037 Simultaneous and async: force_relock plus lock drop in the same cycle -> one lock_lost and lost_cnt+1; rst=0 mid-RUN -> REQ-031 values without waiting for a clock edge.
